// File: rtl/apdtimer_record_packer.sv
// Photon-record packer: buffers 47-bit records in a small FIFO and emits each as three 16-bit words.
// Optional drop accounting (overflow / lost_count) is enabled by defining PACKER_LOST_COUNT_EN.
module apdtimer_record_packer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [46:0] record,
  input  logic        record_rdy,
  input  logic        clear,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        overflow,
  output logic [15:0] lost_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_W0,
    S_W1,
    S_W2
  } state_t;

  state_t        state_q, state_d;
  logic [46:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [46:0]   hold_q, hold_d;
  logic          handshake;
  logic          pop;
  logic          push;

  assign word_valid = (state_q != S_IDLE);
  assign handshake  = word_valid && word_ready;
  // clear wins over a pop; a full FIFO still accepts a write when it pops on the same edge
  assign pop  = !clear && (count_q != '0) &&
                ((state_q == S_IDLE) || ((state_q == S_W2) && handshake));
  assign push = record_rdy && !clear && ((count_q < DEPTH_C) || pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pop) state_d = S_W0;
      S_W0:   if (handshake) state_d = S_W1;
      S_W1:   if (handshake) state_d = S_W2;
      S_W2:   if (handshake) state_d = pop ? S_W0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        hold_d   = mem_q[rd_ptr_q];
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    word = 16'h0000;
    case (state_q)
      S_W0:    word = {1'b1, hold_q[46:32]};
      S_W1:    word = hold_q[31:16];
      S_W2:    word = hold_q[15:0];
      default: word = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= record;
  end

`ifdef PACKER_LOST_COUNT_EN
  logic        drop;
  logic        overflow_q, overflow_d;
  logic [15:0] lost_q, lost_d;

  assign drop = record_rdy && !clear && !push;

  always_comb begin
    overflow_d = overflow_q;
    lost_d     = lost_q;
    if (clear) begin
      overflow_d = 1'b0;
      lost_d     = 16'h0000;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (lost_q != 16'hFFFF) lost_d = lost_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      lost_q     <= 16'h0000;
    end else begin
      overflow_q <= overflow_d;
      lost_q     <= lost_d;
    end
  end

  assign overflow   = overflow_q;
  assign lost_count = lost_q;
`else
  assign overflow   = 1'b0;
  assign lost_count = 16'h0000;
`endif

endmodule

// File: tb/tb_apdtimer_record_packer.sv
// Directed testbench for apdtimer_record_packer (DEPTH = 4); expectations follow PACKER_LOST_COUNT_EN.
module tb_apdtimer_record_packer;

`ifdef PACKER_LOST_COUNT_EN
  localparam logic STATUS_EN = 1'b1;
`else
  localparam logic STATUS_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [46:0] record;
  logic        record_rdy;
  logic        clear;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        overflow;
  logic [15:0] lost_count;

  int total_checks  = 0;
  int passed_checks = 0;
  int failed_checks = 0;

  apdtimer_record_packer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .record     (record),
    .record_rdy (record_rdy),
    .clear      (clear),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .lost_count (lost_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "[TB] timeout");
  end

  // Record i carries recognisable fields; its words are 16'h8100+i, 16'hA000+i, 16'hB000+i.
  function automatic logic [46:0] mk_rec(input int i);
    return {15'h0100 + 15'(i), 16'hA000 + 16'(i), 16'hB000 + 16'(i)};
  endfunction

  function automatic logic [15:0] exp_word(input int i, input int k);
    case (k)
      0:       return 16'h8100 + 16'(i);
      1:       return 16'hA000 + 16'(i);
      default: return 16'hB000 + 16'(i);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else begin
      failed_checks++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [46:0] rec);
    record     = rec;
    record_rdy = 1'b1;
    step();
    record_rdy = 1'b0;
  endtask

  // Expects word_ready=1 and checks n_rec whole records starting with record index first.
  task automatic drain_check(input string tag, input int first, input int n_rec);
    for (int r = 0; r < n_rec; r++) begin
      for (int k = 0; k < 3; k++) begin
        check_output({tag, "_valid"}, {15'b0, word_valid}, 16'h0001);
        check_output({tag, "_word"}, word, exp_word(first + r, k));
        step();
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    record     = '0;
    record_rdy = 1'b0;
    clear      = 1'b0;
    word_ready = 1'b0;
    #1;
    check_output("reset_valid", {15'b0, word_valid}, 16'h0000);
    check_output("reset_word", word, 16'h0000);
    check_output("reset_overflow", {15'b0, overflow}, 16'h0000);
    check_output("reset_lost", lost_count, 16'h0000);
    step();
    step();
    reset_n = 1'b1;
    step();

    $display("[TB] single record");
    word_ready = 1'b1;
    apply_stimulus(47'h7ABC_1234_5678);
    check_output("single_latency_valid", {15'b0, word_valid}, 16'h0000);
    step();
    check_output("single_w0", word, 16'hFABC);
    check_output("single_w0_valid", {15'b0, word_valid}, 16'h0001);
    step();
    check_output("single_w1", word, 16'h1234);
    step();
    check_output("single_w2", word, 16'h5678);
    step();
    check_output("single_after_valid", {15'b0, word_valid}, 16'h0000);

    $display("[TB] backpressure");
    apply_stimulus(47'h7ABC_1234_5678);
    step();
    check_output("bp_w0", word, 16'hFABC);
    step();
    check_output("bp_w1", word, 16'h1234);
    word_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_output("bp_hold_word", word, 16'h1234);
      check_output("bp_hold_valid", {15'b0, word_valid}, 16'h0001);
    end
    word_ready = 1'b1;
    step();
    check_output("bp_w2", word, 16'h5678);
    step();
    check_output("bp_after_valid", {15'b0, word_valid}, 16'h0000);

    $display("[TB] burst with overflow");
    word_ready = 1'b0;
    for (int i = 0; i < 6; i++) apply_stimulus(mk_rec(i));
    check_output("burst_overflow", {15'b0, overflow}, {15'b0, STATUS_EN});
    check_output("burst_lost", lost_count, STATUS_EN ? 16'h0001 : 16'h0000);
    check_output("burst_hold_w0", word, 16'h8100);
    word_ready = 1'b1;
    drain_check("burst", 0, 5);
    check_output("burst_after_valid", {15'b0, word_valid}, 16'h0000);

    $display("[TB] full FIFO with pop on same edge");
    word_ready = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus(mk_rec(i));
    check_output("full_pre_lost", lost_count, STATUS_EN ? 16'h0001 : 16'h0000);
    word_ready = 1'b1;
    step();
    step();
    check_output("full_in_w2", word, 16'hB000);
    apply_stimulus(mk_rec(5));
    check_output("full_lost_unchanged", lost_count, STATUS_EN ? 16'h0001 : 16'h0000);
    drain_check("full", 1, 5);
    check_output("full_after_valid", {15'b0, word_valid}, 16'h0000);

    $display("[TB] clear during W1");
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(mk_rec(i));
    word_ready = 1'b1;
    step();
    check_output("clear_w1", word, 16'hA000);
    clear      = 1'b1;
    record     = mk_rec(7);
    record_rdy = 1'b1;
    step();
    clear      = 1'b0;
    record_rdy = 1'b0;
    check_output("clear_w2", word, 16'hB000);
    check_output("clear_w2_valid", {15'b0, word_valid}, 16'h0001);
    check_output("clear_lost", lost_count, 16'h0000);
    check_output("clear_overflow", {15'b0, overflow}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("clear_idle_valid", {15'b0, word_valid}, 16'h0000);
    end

    $display("[TB] reset mid-W2");
    apply_stimulus(mk_rec(0));
    step();
    step();
    step();
    check_output("rst_in_w2", word, 16'hB000);
    reset_n = 1'b0;
    #1;
    check_output("rst_valid_async", {15'b0, word_valid}, 16'h0000);
    check_output("rst_word_async", word, 16'h0000);
    step();
    reset_n = 1'b1;
    apply_stimulus(mk_rec(2));
    step();
    check_output("rst_new_w0", word, 16'h8102);
    check_output("rst_new_valid", {15'b0, word_valid}, 16'h0001);
    step();
    check_output("rst_new_w1", word, 16'hA002);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
